// File: rtl/conv_window_generator.sv
// Streaming 5x5 window generator: four line buffers plus a shifting window
// register turn a raster pixel stream into every fully valid stride-1 window.
module conv_window_generator #(
  parameter int bitwidth = 16,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic signed [bitwidth-1:0]                in_pixel,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [4:0][4:0][bitwidth-1:0]      map_block,
  output logic        [$clog2(IMG_H)-1:0]           out_row,
  output logic        [$clog2(IMG_W)-1:0]           out_col,
  output logic                                      frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_OFS  = RW'(4);
  localparam logic [CW-1:0] COL_OFS  = CW'(4);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  // win_q[i][j]: row offset i (0 = oldest row), column offset j (4 = newest)
  logic [4:0][4:0][bitwidth-1:0]       win_q, win_d;
  // lb_q[0] holds row r-4, lb_q[3] holds row r-1 at every column
  logic [3:0][IMG_W-1:0][bitwidth-1:0] lb_q, lb_d;

  logic accept;
  logic emit;
  logic hold;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
  assign map_block  = win_q;

  always_comb begin
    accept = in_valid && in_ready;
    emit   = accept && (row_q >= ROW_OFS) && (col_q >= COL_OFS);
    hold   = out_valid_q && !out_ready;

    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    out_valid_d  = emit || hold;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = frame_done_q && hold;
    if (emit) begin
      out_row_d    = row_q - ROW_OFS;
      out_col_d    = col_q - COL_OFS;
      frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  // The window only moves on accept, so it also serves as the held output.
  always_comb begin
    win_d = win_q;
    lb_d  = lb_q;
    if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      for (int k = 0; k < 4; k++) begin
        win_d[k][4] = lb_q[k][col_q];
      end
      win_d[4][4] = in_pixel;
      for (int k = 0; k < 3; k++) begin
        lb_d[k][col_q] = lb_q[k+1][col_q];
      end
      lb_d[3][col_q] = in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffer contents are don't-care until four rows are rewritten.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule

// File: tb/tb_conv_window_generator.sv
// Directed bench for conv_window_generator: ramp, backpressure, random
// handshakes, mid-frame reset and signed-extreme frames.
module tb_conv_window_generator;

  localparam int BW = 16;
  localparam int W  = 28;
  localparam int H  = 28;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic signed [BW-1:0]          in_pixel;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [4:0][4:0][BW-1:0] map_block;
  logic [4:0]                    out_row;
  logic [4:0]                    out_col;
  logic                          frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_window_generator #(.bitwidth(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .map_block (map_block),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  // pattern 0: ramp r*28+c; pattern 1: all -1 with -32768 at (10,10)
  function automatic logic [15:0] pix(input int pat, input int r, input int c);
    if (pat == 0) return 16'(r * W + c);
    if (r == 10 && c == 10) return 16'h8000;
    return 16'hFFFF;
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives nframes of a pattern and scores every consumed window against pix().
  task automatic run_stream(input int nframes, input int pv, input int pr, input int pat,
                            input int stall, input int abort_after,
                            output int nwin, output int nfd, output int bad,
                            output int maxcol, output int stall_bad, output int nstall,
                            output logic [15:0] w66);
    int total;
    int pidx;
    int er;
    int ec;
    int stall_left;
    int cyc;
    int idx;
    bit stalled;
    bit in_stall;
    bit ok;
    logic [4:0][4:0][BW-1:0] snap;
    logic [4:0] snap_r;
    logic [4:0] snap_c;
    total = nframes * W * H;
    pidx = 0; er = 0; ec = 0; stall_left = 0; cyc = 0; stalled = 0;
    snap = '0; snap_r = '0; snap_c = '0;
    nwin = 0; nfd = 0; bad = 0; maxcol = 0; stall_bad = 0; nstall = 0; w66 = '0;
    while (nwin < nframes * (H - 4) * (W - 4) && cyc < 40000) begin
      cyc++;
      @(negedge clk);
      idx       = pidx % (W * H);
      in_valid  = (pidx < total) && ($urandom_range(99) < pv);
      in_pixel  = pix(pat, idx / W, idx % W);
      out_ready = ($urandom_range(99) < pr);
      in_stall  = 1'b0;
      if (stall != 0 && !stalled && out_valid && out_row == 5 && out_col == 7) begin
        stalled    = 1'b1;
        stall_left = 10;
        snap       = map_block;
        snap_r     = out_row;
        snap_c     = out_col;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        in_stall = 1'b1;
        nstall++;
      end
      #1;
      if (in_stall && (in_ready !== 1'b0 || out_valid !== 1'b1 || map_block !== snap ||
                       out_row !== snap_r || out_col !== snap_c))
        stall_bad++;
      if (out_valid && out_ready) begin
        ok = 1'b1;
        if (out_row !== 5'(er)) ok = 1'b0;
        if (out_col !== 5'(ec)) ok = 1'b0;
        if (frame_done !== ((er == H - 5) && (ec == W - 5))) ok = 1'b0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            if (map_block[i][j] !== pix(pat, er + i, ec + j)) ok = 1'b0;
        if (!ok) bad++;
        if (frame_done) nfd++;
        if (int'(out_col) > maxcol) maxcol = int'(out_col);
        if (er == 6 && ec == 6) w66 = map_block[4][4];
        nwin++;
        ec++;
        if (ec == W - 4) begin
          ec = 0;
          er++;
          if (er == H - 4) er = 0;
        end
      end
      if (in_valid && in_ready) begin
        pidx++;
        if (abort_after > 0 && pidx >= abort_after) break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: out_valid=%b frame_done=%b expected 0 0", out_valid, frame_done);
    end
    tests++;
    if (out_row !== 5'd0 || out_col !== 5'd0) begin
      fails++;
      $display("FAIL reset_pos: row=%0d col=%0d expected 0 0", out_row, out_col);
    end
    tests++;
    if (map_block !== '0) begin
      fails++;
      $display("FAIL reset_block: map_block=%h expected 0", map_block);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_first_window();
    int early;
    early = 0;
    for (int k = 0; k <= 116; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_pixel = 16'(k); out_ready = 1'b1;
      #1;
      if (out_valid !== 1'b0) early++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL first_no_early: got %0d early windows expected 0", early);
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_valid: got %b expected 1", out_valid);
    end
    tests++;
    if (map_block[0][0] !== 16'd0 || map_block[4][4] !== 16'd116 || map_block[2][3] !== 16'd59) begin
      fails++;
      $display("FAIL first_block: [0][0]=%0d [4][4]=%0d [2][3]=%0d expected 0 116 59",
               map_block[0][0], map_block[4][4], map_block[2][3]);
    end
    tests++;
    if (out_row !== 5'd0 || out_col !== 5'd0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL first_pos: row=%0d col=%0d fd=%b expected 0 0 0", out_row, out_col, frame_done);
    end
  endtask

  task automatic test_ramp_frame();
    int nwin, nfd, bad, maxcol, sbad, nst;
    logic [15:0] w66;
    run_stream(1, 100, 100, 0, 0, 0, nwin, nfd, bad, maxcol, sbad, nst, w66);
    tests++;
    if (nwin != 576) begin fails++; $display("FAIL ramp_count: got %0d expected 576", nwin); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ramp_content: got %0d bad windows expected 0", bad); end
    tests++;
    if (nfd != 1) begin fails++; $display("FAIL ramp_frame_done: got %0d expected 1", nfd); end
  endtask

  task automatic test_backpressure();
    int nwin, nfd, bad, maxcol, sbad, nst;
    logic [15:0] w66;
    run_stream(1, 100, 100, 0, 1, 0, nwin, nfd, bad, maxcol, sbad, nst, w66);
    tests++;
    if (nst != 10) begin fails++; $display("FAIL bp_stall_cycles: got %0d expected 10", nst); end
    tests++;
    if (sbad != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", sbad); end
    tests++;
    if (nwin != 576 || bad != 0) begin
      fails++;
      $display("FAIL bp_sequence: got %0d windows %0d bad expected 576 0", nwin, bad);
    end
  endtask

  task automatic test_back_to_back_random();
    int nwin, nfd, bad, maxcol, sbad, nst;
    logic [15:0] w66;
    run_stream(3, 50, 70, 0, 0, 0, nwin, nfd, bad, maxcol, sbad, nst, w66);
    tests++;
    if (nwin != 1728) begin fails++; $display("FAIL rand_count: got %0d expected 1728", nwin); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rand_content: got %0d bad windows expected 0", bad); end
    tests++;
    if (nfd != 3) begin fails++; $display("FAIL rand_frame_done: got %0d expected 3", nfd); end
    tests++;
    if (maxcol > 23) begin fails++; $display("FAIL rand_max_col: got %0d expected <=23", maxcol); end
  endtask

  task automatic test_reset_mid_frame();
    int nwin, nfd, bad, maxcol, sbad, nst;
    logic [15:0] w66;
    run_stream(1, 100, 100, 0, 0, 300, nwin, nfd, bad, maxcol, sbad, nst, w66);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0) begin
      fails++;
      $display("FAIL midrst_async: valid=%b fd=%b row=%0d col=%0d expected 0 0 0 0",
               out_valid, frame_done, out_row, out_col);
    end
    tests++;
    if (map_block !== '0) begin
      fails++;
      $display("FAIL midrst_block: map_block=%h expected 0", map_block);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_stream(1, 100, 100, 0, 0, 0, nwin, nfd, bad, maxcol, sbad, nst, w66);
    tests++;
    if (nwin != 576 || bad != 0) begin
      fails++;
      $display("FAIL midrst_fresh: got %0d windows %0d bad expected 576 0", nwin, bad);
    end
  endtask

  task automatic test_signed();
    int nwin, nfd, bad, maxcol, sbad, nst;
    logic [15:0] w66;
    run_stream(1, 100, 100, 1, 0, 0, nwin, nfd, bad, maxcol, sbad, nst, w66);
    tests++;
    if (nwin != 576 || bad != 0) begin
      fails++;
      $display("FAIL signed_content: got %0d windows %0d bad expected 576 0", nwin, bad);
    end
    tests++;
    if (w66 !== 16'h8000) begin
      fails++;
      $display("FAIL signed_w66: got %h expected 8000", w66);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    do_reset();
    test_ramp_frame();
    do_reset();
    test_backpressure();
    do_reset();
    test_back_to_back_random();
    do_reset();
    test_reset_mid_frame();
    do_reset();
    test_signed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
